// File: rtl/liafn_pkg.sv
// Shared types and default constants for the leaky-integrate-and-fire sweep scheduler.
// The update datapath and the scheduler both import this package.
package liafn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } sweep_state_e;

   localparam int DEF_NUM_NEURONS     = 8;
   localparam int DEF_LEAK_SHIFT      = 3;
   localparam int DEF_FIRE_THRESHOLD  = 200;
   localparam int DEF_DELTA_THRESHOLD = 10;

   localparam int STATE_W = 8;
   localparam int CUR_W   = 8;
   // Delta spans -(255>>LEAK_SHIFT)..255, so 9 signed bits never overflow.
   localparam int DELTA_W = 9;
   localparam int SUM_W   = 10;

endpackage

// File: rtl/liafn_update_unit.sv
// Combinational LIF step for one neuron: leak, integrate, saturate, fire and delta detection.
// Produces the value to write back plus the event fields.
module liafn_update_unit
   import liafn_pkg::*;
#(
   parameter int LEAK_SHIFT      = DEF_LEAK_SHIFT,
   parameter int FIRE_THRESHOLD  = DEF_FIRE_THRESHOLD,
   parameter int DELTA_THRESHOLD = DEF_DELTA_THRESHOLD
) (
   input  logic [STATE_W-1:0]        old_state,
   input  logic [CUR_W-1:0]          cur,
   output logic [STATE_W-1:0]        store_state,
   output logic signed [DELTA_W-1:0] delta,
   output logic                      fire,
   output logic                      evt
);

   localparam logic [STATE_W-1:0]        FIRE_TH  = STATE_W'(FIRE_THRESHOLD);
   localparam logic signed [DELTA_W-1:0] DELTA_TH = DELTA_W'(DELTA_THRESHOLD);

   logic [SUM_W-1:0]   sum;
   logic [STATE_W-1:0] new_state;

   always_comb begin
      sum         = SUM_W'(old_state) - SUM_W'(old_state >> LEAK_SHIFT) + SUM_W'(cur);
      new_state   = (sum > SUM_W'(255)) ? {STATE_W{1'b1}} : sum[STATE_W-1:0];
      fire        = (new_state >= FIRE_TH);
      delta       = $signed({1'b0, new_state}) - $signed({1'b0, old_state});
      // A firing neuron always reports, even when its delta is negative.
      evt         = fire || (delta >= DELTA_TH);
      store_state = fire ? '0 : new_state;
   end

endmodule

// File: rtl/liafn_sweep_scheduler.sv
// Sweeps NUM_NEURONS virtual LIF neurons through one shared update unit, one per cycle,
// emitting delta/fire events on a valid/ready stream whose backpressure stalls the sweep.
module liafn_sweep_scheduler
   import liafn_pkg::*;
#(
   parameter int  NUM_NEURONS     = DEF_NUM_NEURONS,
   parameter int  LEAK_SHIFT      = DEF_LEAK_SHIFT,
   parameter int  FIRE_THRESHOLD  = DEF_FIRE_THRESHOLD,
   parameter int  DELTA_THRESHOLD = DEF_DELTA_THRESHOLD,
   localparam int IDX_W           = $clog2(NUM_NEURONS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      tick,
   output logic                      busy,
   output logic                      sweep_done,
   output logic                      overrun,
   input  logic                      cur_we,
   input  logic [IDX_W-1:0]          cur_addr,
   input  logic [CUR_W-1:0]          cur_data,
   input  logic [IDX_W-1:0]          state_rd_addr,
   output logic [STATE_W-1:0]        state_rd_data,
   output logic                      evt_valid,
   input  logic                      evt_ready,
   output logic [IDX_W-1:0]          evt_idx,
   output logic signed [DELTA_W-1:0] evt_delta,
   output logic                      evt_fire
);

   // Event stream: an event transfers on any rising edge where evt_valid && evt_ready;
   // while evt_valid && !evt_ready the event fields are held unchanged.

   sweep_state_e              state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [CUR_W-1:0]          cur_q [NUM_NEURONS];
   logic [CUR_W-1:0]          cur_d [NUM_NEURONS];
   logic [STATE_W-1:0]        mem_q [NUM_NEURONS];
   logic [STATE_W-1:0]        mem_d [NUM_NEURONS];
   logic                      evt_valid_q, evt_valid_d;
   logic [IDX_W-1:0]          evt_idx_q, evt_idx_d;
   logic signed [DELTA_W-1:0] evt_delta_q, evt_delta_d;
   logic                      evt_fire_q, evt_fire_d;
   logic                      overrun_q, overrun_d;

   logic                      process;
   logic [STATE_W-1:0]        upd_store;
   logic signed [DELTA_W-1:0] upd_delta;
   logic                      upd_fire;
   logic                      upd_evt;

   liafn_update_unit #(
      .LEAK_SHIFT      (LEAK_SHIFT),
      .FIRE_THRESHOLD  (FIRE_THRESHOLD),
      .DELTA_THRESHOLD (DELTA_THRESHOLD)
   ) u_update (
      .old_state   (mem_q[idx_q]),
      .cur         (cur_q[idx_q]),
      .store_state (upd_store),
      .delta       (upd_delta),
      .fire        (upd_fire),
      .evt         (upd_evt)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cur_d       = cur_q;
      mem_d       = mem_q;
      evt_valid_d = evt_valid_q;
      evt_idx_d   = evt_idx_q;
      evt_delta_d = evt_delta_q;
      evt_fire_d  = evt_fire_q;
      overrun_d   = tick && (state_q != ST_IDLE);
      // A neuron may only be processed if its possible event has somewhere to go.
      process     = (state_q == ST_UPDATE) && (!evt_valid_q || evt_ready);

      unique case (state_q)
         ST_IDLE: begin
            if (tick) begin
               state_d = ST_UPDATE;
               idx_d   = '0;
            end
         end
         ST_UPDATE: begin
            if (process) begin
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (process) begin
         mem_d[idx_q] = upd_store;
      end
      // The update above reads the pre-write current, so a colliding write lands next sweep.
      if (cur_we) begin
         cur_d[cur_addr] = cur_data;
      end

      if (process && upd_evt) begin
         evt_valid_d = 1'b1;
         evt_idx_d   = idx_q;
         evt_delta_d = upd_delta;
         evt_fire_d  = upd_fire;
      end else if (evt_valid_q && evt_ready) begin
         evt_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         cur_q       <= '{default: '0};
         mem_q       <= '{default: '0};
         evt_valid_q <= 1'b0;
         evt_idx_q   <= '0;
         evt_delta_q <= '0;
         evt_fire_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cur_q       <= cur_d;
         mem_q       <= mem_d;
         evt_valid_q <= evt_valid_d;
         evt_idx_q   <= evt_idx_d;
         evt_delta_q <= evt_delta_d;
         evt_fire_q  <= evt_fire_d;
         overrun_q   <= overrun_d;
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign sweep_done    = (state_q == ST_DONE);
   assign overrun       = overrun_q;
   assign state_rd_data = mem_q[state_rd_addr];
   assign evt_valid     = evt_valid_q;
   assign evt_idx       = evt_idx_q;
   assign evt_delta     = evt_delta_q;
   assign evt_fire      = evt_fire_q;

endmodule

// File: tb/tb_liafn_sweep_scheduler.sv
// Directed bench for liafn_sweep_scheduler: a neuron-level reference model checked every
// cycle, an event scoreboard, and literal expectations for each scenario.
module tb_liafn_sweep_scheduler;

   localparam int N  = 8;
   localparam int IW = 3;
   localparam int LS = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tick = 1'b0;
   logic          cur_we = 1'b0;
   logic [IW-1:0] cur_addr = '0;
   logic [7:0]    cur_data = '0;
   logic [IW-1:0] state_rd_addr = '0;
   logic          evt_ready = 1'b1;
   logic          busy, sweep_done, overrun, evt_valid, evt_fire;
   logic [7:0]    state_rd_data;
   logic [IW-1:0] evt_idx;
   logic [8:0]    evt_delta;

   always #5 clk = ~clk;

   liafn_sweep_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .busy          (busy),
      .sweep_done    (sweep_done),
      .overrun       (overrun),
      .cur_we        (cur_we),
      .cur_addr      (cur_addr),
      .cur_data      (cur_data),
      .state_rd_addr (state_rd_addr),
      .state_rd_data (state_rd_data),
      .evt_valid     (evt_valid),
      .evt_ready     (evt_ready),
      .evt_idx       (evt_idx),
      .evt_delta     (evt_delta),
      .evt_fire      (evt_fire)
   );

   typedef struct {
      int idx;
      int delta;
      int fire;
   } ev_t;

   ev_t exp_q[$];
   ev_t got_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference model: a sweep is a walk over neurons 0..N-1; each neuron either advances
   // (output slot free or draining) or waits. m_* hold what the outputs must show.
   int m_cur [N];
   int m_st  [N];
   bit m_active, m_done, m_overrun, m_ev_valid, m_ev_fire;
   int m_k, m_ev_idx, m_ev_delta;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_cur[i] = 0;
         m_st[i]  = 0;
      end
      m_active   = 0;
      m_done     = 0;
      m_overrun  = 0;
      m_ev_valid = 0;
      m_ev_fire  = 0;
      m_k        = 0;
      m_ev_idx   = 0;
      m_ev_delta = 0;
      exp_q.delete();
   endfunction

   function automatic void model_step();
      bit  hs, adv, fr;
      int  old_v, c, sum, nw, dl;
      ev_t e;
      hs = m_ev_valid && evt_ready;
      if (hs) begin
         e.idx   = int'(evt_idx);
         e.delta = int'($signed(evt_delta));
         e.fire  = int'(evt_fire);
         got_q.push_back(e);
         if (exp_q.size() == 0) begin
            check("sb_unexpected_event", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("sb_idx", int'(evt_idx), e.idx);
            check("sb_delta", int'($signed(evt_delta)), e.delta);
            check("sb_fire", int'(evt_fire), e.fire);
         end
         m_ev_valid = 0;
      end
      adv       = m_active && (!hs ? !m_ev_valid : 1'b1);
      m_overrun = tick && (m_active || m_done);
      if (adv) begin
         old_v = m_st[m_k];
         c     = m_cur[m_k];
         sum   = old_v - old_v / (2 ** LS) + c;
         nw    = (sum > 255) ? 255 : sum;
         fr    = (nw >= 200);
         dl    = nw - old_v;
         m_st[m_k] = fr ? 0 : nw;
         if (fr || dl >= 10) begin
            m_ev_valid = 1;
            m_ev_idx   = m_k;
            m_ev_delta = dl;
            m_ev_fire  = fr;
            e.idx      = m_k;
            e.delta    = dl;
            e.fire     = int'(fr);
            exp_q.push_back(e);
         end
         if (m_k == N - 1) begin
            m_active = 0;
            m_done   = 1;
         end else begin
            m_k++;
         end
      end else if (m_done) begin
         m_done = 0;
      end else if (!m_active && tick) begin
         m_active = 1;
         m_k      = 0;
      end
      if (cur_we) m_cur[cur_addr] = int'(cur_data);
   endfunction

   always @(negedge clk) begin : compare
      if (!rst_n) model_reset();
      check("cyc_evt_valid", int'(evt_valid), int'(m_ev_valid));
      check("cyc_busy", int'(busy), int'(m_active || m_done));
      check("cyc_sweep_done", int'(sweep_done), int'(m_done));
      check("cyc_overrun", int'(overrun), int'(m_overrun));
      check("cyc_evt_idx", int'(evt_idx), m_ev_idx);
      check("cyc_evt_delta", int'($signed(evt_delta)), m_ev_delta);
      check("cyc_evt_fire", int'(evt_fire), int'(m_ev_fire));
      check("cyc_state_rd", int'(state_rd_data), m_st[state_rd_addr]);
      if (rst_n) model_step();
   end

   // Driver tasks: all input changes happen 2 time units after a rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      tick      = 1'b0;
      cur_we    = 1'b0;
      evt_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic write_cur(input int a, input int d);
      cur_we   = 1'b1;
      cur_addr = IW'(a);
      cur_data = 8'(d);
      step();
      cur_we = 1'b0;
   endtask

   task automatic read_state(input string name, input int a, input int exp);
      state_rd_addr = IW'(a);
      @(negedge clk);
      check(name, int'(state_rd_data), exp);
      step();
   endtask

   // Runs one sweep; cycle n counts from the cycle after tick was sampled.
   task automatic sweep(input int ovr_at, input int wr_at, input int wr_addr, input int wr_data,
                        input int stall_len, output int done_at, output int busy_cnt,
                        output int ovr_cnt);
      int nf;
      nf       = 0;
      done_at  = -1;
      busy_cnt = 0;
      ovr_cnt  = 0;
      got_q.delete();
      tick      = 1'b1;
      evt_ready = (stall_len == 0);
      @(negedge clk);
      step();
      for (int n = 1; n <= 60; n++) begin
         tick   = (n == ovr_at);
         cur_we = (n == wr_at);
         if (n == wr_at) begin
            cur_addr = IW'(wr_addr);
            cur_data = 8'(wr_data);
         end
         evt_ready = (stall_len == 0) || (nf > 0 && n >= nf + stall_len);
         @(negedge clk);
         if (busy) busy_cnt++;
         if (overrun) ovr_cnt++;
         if (evt_valid && nf == 0) nf = n;
         if (sweep_done) begin
            done_at = n;
            step();
            break;
         end
         step();
      end
      tick      = 1'b0;
      cur_we    = 1'b0;
      evt_ready = 1'b1;
      if (done_at < 0) check("sweep_timeout", 0, 1);
      repeat (4) step();
   endtask

   initial begin : main
      int d, b, o;
      repeat (2) step();
      rst_n = 1'b1;
      step();

      // 1: zero currents
      sweep(0, 0, 0, 0, 0, d, b, o);
      check("t1_done_at", d, 9);
      check("t1_busy_cycles", b, 9);
      check("t1_no_events", got_q.size(), 0);

      // 2: delta path
      do_reset();
      write_cur(2, 20);
      sweep(0, 0, 0, 0, 0, d, b, o);
      check("t2a_count", got_q.size(), 1);
      if (got_q.size() == 1) begin
         check("t2a_idx", got_q[0].idx, 2);
         check("t2a_delta", got_q[0].delta, 20);
         check("t2a_fire", got_q[0].fire, 0);
      end
      read_state("t2a_state2", 2, 20);
      sweep(0, 0, 0, 0, 0, d, b, o);
      check("t2b_count", got_q.size(), 1);
      if (got_q.size() == 1) check("t2b_delta", got_q[0].delta, 18);
      read_state("t2b_state2", 2, 38);
      write_cur(2, 5);
      sweep(0, 0, 0, 0, 0, d, b, o);
      check("t2c_no_event", got_q.size(), 0);
      read_state("t2c_state2", 2, 39);

      // 3: fire and saturation
      do_reset();
      write_cur(5, 255);
      sweep(0, 0, 0, 0, 0, d, b, o);
      check("t3_count", got_q.size(), 1);
      if (got_q.size() == 1) begin
         check("t3_idx", got_q[0].idx, 5);
         check("t3_delta", got_q[0].delta, 255);
         check("t3_fire", got_q[0].fire, 1);
      end
      read_state("t3_state5", 5, 0);

      // 4: backpressure
      do_reset();
      for (int i = 0; i < N; i++) write_cur(i, 15);
      sweep(0, 0, 0, 0, 5, d, b, o);
      check("t4_done_at", d, 14);
      check("t4_count", got_q.size(), 8);
      for (int i = 0; i < got_q.size(); i++) begin
         check("t4_order_idx", got_q[i].idx, i);
         check("t4_delta", got_q[i].delta, 15);
      end

      // 5: overrun, then write collision
      do_reset();
      sweep(3, 0, 0, 0, 0, d, b, o);
      check("t5_overrun_pulses", o, 1);
      check("t5_no_restart_done_at", d, 9);
      do_reset();
      write_cur(3, 12);
      sweep(0, 4, 3, 40, 0, d, b, o);
      check("t5_collide_count", got_q.size(), 1);
      if (got_q.size() == 1) begin
         check("t5_collide_idx", got_q[0].idx, 3);
         check("t5_collide_delta", got_q[0].delta, 12);
      end
      sweep(0, 0, 0, 0, 0, d, b, o);
      check("t5_next_count", got_q.size(), 1);
      if (got_q.size() == 1) check("t5_next_delta", got_q[0].delta, 39);
      read_state("t5_state3", 3, 51);

      // 6: reset mid-sweep
      do_reset();
      for (int i = 0; i < N; i++) write_cur(i, 15);
      state_rd_addr = '0;
      evt_ready     = 1'b0;
      tick          = 1'b1;
      @(negedge clk);
      step();
      tick = 1'b0;
      repeat (3) step();
      check("t6_pre_valid", int'(evt_valid), 1);
      check("t6_pre_state0", int'(state_rd_data), 15);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", int'(evt_valid), 0);
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_state", int'(state_rd_data), 0);
      step();
      rst_n     = 1'b1;
      evt_ready = 1'b1;
      step();
      for (int i = 0; i < N; i++) write_cur(i, 15);
      sweep(0, 0, 0, 0, 0, d, b, o);
      check("t6_clean_done_at", d, 9);
      check("t6_clean_count", got_q.size(), 8);

      repeat (3) step();
      check("final_exp_q_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/liafn_sweep_scheduler.md
Name: liafn_sweep_scheduler

Overview:
- Time-multiplexes one leaky-integrate-and-fire update datapath across NUM_NEURONS virtual neurons.
- Holds per-neuron input current and membrane state in register arrays.
- On each tick, sweeps every neuron in index order, one per cycle. Each update applies leak, integration, fire detection and delta detection.
- Delta and fire events leave on a valid/ready stream; downstream backpressure stalls the sweep. The block sits between the host I/O mux and the event output pins.

Parameters:
- NUM_NEURONS, 8: number of virtual neurons; power of two, 2..32.
- LEAK_SHIFT, 3: leak = state >> LEAK_SHIFT.
- FIRE_THRESHOLD, 200: unsigned 8-bit; new state >= this fires.
- DELTA_THRESHOLD, 10: signed delta >= this raises a delta event.
- IDX_W, clog2(NUM_NEURONS): index width; derived, not overridden.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- tick, input, 1: start-sweep pulse.
- busy, output, 1: sweep in progress.
- sweep_done, output, 1: one-cycle pulse at end of sweep.
- overrun, output, 1: one-cycle pulse when tick arrives while not IDLE.
- cur_we, input, 1: current write enable.
- cur_addr, input, IDX_W: current write index.
- cur_data, input, 8: unsigned current value.
- state_rd_addr, input, IDX_W: state read index.
- state_rd_data, output, 8: combinational read of state[state_rd_addr].
- evt_valid, output, 1: event available.
- evt_ready, input, 1: consumer accepts the event.
- evt_idx, output, IDX_W: neuron index of the event.
- evt_delta, output, 9: signed new_state - old_state.
- evt_fire, output, 1: event caused by threshold crossing.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; index 0.
  - cur[] and state[] all 0.
  - evt_valid, busy, sweep_done and overrun all 0; evt_idx, evt_delta and evt_fire 0.
  - Reset mid-sweep aborts the sweep. The pending event is dropped, and state_rd_data reads 0 immediately.
- FSM states: IDLE, UPDATE, DONE.
  - IDLE: tick=1 -> UPDATE, index=0.
  - UPDATE: when neuron `index` is processed this cycle, index+1. If index==NUM_NEURONS-1, -> DONE.
  - DONE: one cycle with sweep_done=1, then -> IDLE.
- busy = (FSM != IDLE).
- tick is accepted only in IDLE. tick in UPDATE or DONE is ignored and pulses overrun the next cycle.
- Update arithmetic for neuron i, old=state[i], c=cur[i]:
  - sum = old - (old >> LEAK_SHIFT) + c, computed 10-bit unsigned.
  - new = min(sum, 255).
  - fire = (new >= FIRE_THRESHOLD).
  - delta = new - old as 9-bit signed; range -(255>>LEAK_SHIFT)..255, so no overflow.
  - Writeback: state[i] = fire ? 0 : new.
  - Event generated if fire OR (delta >= DELTA_THRESHOLD, signed compare). A negative delta with fire=1 is still reported.
- Process condition in UPDATE: the output slot is free or draining (evt_valid==0 OR evt_ready==1). Otherwise the cycle stalls: no writeback, index held.
- Event register:
  - Loaded on the clock edge that processes an event-generating neuron; evt_valid rises the next cycle.
  - Held stable while evt_valid && !evt_ready.
  - Cleared on handshake unless reloaded the same edge.
  - Events leave in ascending index order; none are lost or duplicated.
  - DONE and IDLE do not wait for the last event to drain. A pending event stays valid until accepted.
- Latency with no stalls:
  - tick sampled in IDLE at cycle T; neuron k processed at T+1+k.
  - Its event is valid at T+2+k.
  - sweep_done at T+NUM_NEURONS+1; busy high T+1..T+NUM_NEURONS+1.
  - Each stall cycle adds one cycle to all later timing.
- Current writes:
  - Take effect on the edge, in any FSM state.
  - A write to neuron i in the cycle i is processed: the update uses the old cur[i], and the array stores the new value.
- state_rd_data reflects the writeback from the following cycle.

Decomposition:
- Package liafn_pkg:
  - FSM state enum (IDLE/UPDATE/DONE).
  - Default constants: NUM_NEURONS, LEAK_SHIFT, FIRE_THRESHOLD, DELTA_THRESHOLD.
  - Event field widths.
- Sub-module liafn_update_unit: purely combinational. Inputs old and c; outputs new-to-store, delta, fire and event. It holds the arithmetic and compares; the scheduler holds the arrays, FSM, and event register.

Test Plan:
1. Zero currents: reset, all cur=0, tick at T. Required: no evt_valid; busy high T+1..T+9; sweep_done pulse at T+9 (N=8).
2. Delta path: cur[2]=20, evt_ready=1, tick.
   - First sweep: one event idx=2, delta=+20, fire=0; state[2] reads 20.
   - Second tick: new=20-2+20=38, event delta=+18.
   - Set cur[2]=5 and tick: new=38-4+5=39, delta=+1, no event.
3. Fire and saturation: cur[5]=255, tick. Required: event idx=5, delta=+255, fire=1; state[5] reads 0 afterwards.
4. Backpressure: all cur=15, evt_ready=0 for 5 cycles after the first evt_valid.
   - evt_idx=0 and delta=15 held stable while stalled; the sweep stalls.
   - Then eight events arrive in order 0..7; sweep_done is 5 cycles late.
5. Overrun and write collision:
   - Tick during UPDATE: overrun pulses, no restart.
   - cur_we to neuron 3 during its process cycle with cur 12->40: event delta=+12; next sweep uses 40.
6. Reset mid-sweep: rst_n low while busy with evt_valid=1. Required, immediately: evt_valid=0, busy=0, state_rd_data=0; the next tick after release runs a full clean sweep.
